// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the prefetch issue path.
package prefetch_pkg;
  typedef logic [31:0] addr_t;
  typedef enum logic [1:0] {IDLE, REQ, CREDIT_WAIT} issue_state_t;

  localparam int CNT_W = 16;

  function automatic int unsigned grid_cells(int unsigned x, int unsigned y, int unsigned z);
    return x * y * z;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/pf_addr_fifo.sv
// Address FIFO with wrap-bit pointers; exposes every slot for a parallel duplicate compare.
module pf_addr_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  addr_t                   push_addr,
  input  logic                    pop,
  output addr_t                   head,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH-1:0]        ent_valid,
  output addr_t [DEPTH-1:0]       ent_addr
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr, rd_ptr, count;
  addr_t [DEPTH-1:0]  mem;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign ent_addr = mem;

  // A slot is live when its distance from the read pointer is below the fill level.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [AW-1:0] off;
    assign off          = AW'(i) - rd_ptr[AW-1:0];
    assign ent_valid[i] = ({1'b0, off} < count);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_addr;
  end
endmodule

// File: rtl/prefetch_issue_queue.sv
// Filters prefetch addresses (grid bound, duplicates, overflow), queues them and issues
// memory reads under an outstanding-read cap.
module prefetch_issue_queue
  import prefetch_pkg::*;
#(
  parameter int XSIZE     = 3,
  parameter int YSIZE     = 3,
  parameter int ZSIZE     = 3,
  parameter int DEPTH     = 8,
  parameter int FILTER_N  = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            pf_valid_i,
  input  logic [31:0]                     pf_addr_i,
  input  logic                            flush_i,
  output logic                            mem_req_valid_o,
  output logic [31:0]                     mem_req_addr_o,
  input  logic                            mem_req_ready_i,
  input  logic                            mem_rsp_valid_i,
  output logic [$clog2(MAX_OUTST+1)-1:0]  outstanding_o,
  output logic [CNT_W-1:0]                drop_oob_o,
  output logic [CNT_W-1:0]                drop_dup_o,
  output logic [CNT_W-1:0]                drop_ovf_o,
  output logic                            rsp_err_o
);
  localparam int unsigned CELLS = grid_cells(XSIZE, YSIZE, ZSIZE);
  localparam int OW = $clog2(MAX_OUTST+1);
  localparam int FW = (FILTER_N > 1) ? $clog2(FILTER_N) : 1;

  issue_state_t         state, state_nxt;
  addr_t                req_addr, head;
  logic                 pop, push, hs, full, empty, avail;
  logic [DEPTH-1:0]     ent_valid;
  addr_t [DEPTH-1:0]    ent_addr;
  addr_t [FILTER_N-1:0] flt_addr;
  logic [FILTER_N-1:0]  flt_valid;
  logic [FW-1:0]        flt_ptr;
  logic [OW-1:0]        out_cnt, out_nxt;
  logic                 err_set, oob, dup, fifo_hit, flt_hit;

  pf_addr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .clear(flush_i),
    .push(push), .push_addr(pf_addr_i), .pop(pop), .head(head),
    .full(full), .empty(empty), .ent_valid(ent_valid), .ent_addr(ent_addr)
  );

  assign mem_req_valid_o = (state == REQ);
  assign mem_req_addr_o  = req_addr;
  assign outstanding_o   = out_cnt;
  assign hs              = mem_req_valid_o & mem_req_ready_i;

  always_comb begin
    fifo_hit = 1'b0;
    flt_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i] && ent_addr[i] == pf_addr_i) fifo_hit = 1'b1;
    for (int i = 0; i < FILTER_N; i++)
      if (flt_valid[i] && flt_addr[i] == pf_addr_i) flt_hit = 1'b1;
  end

  assign oob  = (pf_addr_i >= addr_t'(CELLS));
  assign dup  = fifo_hit | flt_hit | (mem_req_valid_o && req_addr == pf_addr_i);
  assign push = pf_valid_i & ~oob & ~dup & ~full & ~flush_i;

  always_comb begin
    out_nxt = out_cnt;
    err_set = 1'b0;
    if (hs && !mem_rsp_valid_i)      out_nxt = out_cnt + OW'(1);
    else if (!hs && mem_rsp_valid_i) begin
      if (out_cnt == '0) err_set = 1'b1;
      else               out_nxt = out_cnt - OW'(1);
    end
  end

  // A flushing FIFO is treated as empty so nothing is popped out from under the clear.
  assign avail = ~empty & ~flush_i;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (avail) begin
        if (out_cnt < OW'(MAX_OUTST)) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end else state_nxt = CREDIT_WAIT;
      end
      REQ: if (hs) begin
        if (avail && out_nxt < OW'(MAX_OUTST)) pop = 1'b1;
        else if (avail)                        state_nxt = CREDIT_WAIT;
        else                                   state_nxt = IDLE;
      end
      CREDIT_WAIT: if (out_cnt < OW'(MAX_OUTST) || empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      out_cnt    <= '0;
      rsp_err_o  <= 1'b0;
      flt_addr   <= '0;
      flt_valid  <= '0;
      flt_ptr    <= '0;
      drop_oob_o <= '0;
      drop_dup_o <= '0;
      drop_ovf_o <= '0;
    end else begin
      state   <= state_nxt;
      out_cnt <= out_nxt;
      if (err_set) rsp_err_o <= 1'b1;
      if (pop)     req_addr  <= head;
      if (hs) begin
        flt_addr[flt_ptr]  <= req_addr;
        flt_valid[flt_ptr] <= 1'b1;
        flt_ptr <= (flt_ptr == FW'(FILTER_N-1)) ? '0 : flt_ptr + 1'b1;
      end
      // Flush overrides a same-cycle filter write.
      if (flush_i) flt_valid <= '0;
      if (pf_valid_i && oob)                drop_oob_o <= sat_inc(drop_oob_o);
      if (pf_valid_i && !oob && dup)        drop_dup_o <= sat_inc(drop_dup_o);
      if (pf_valid_i && !oob && !dup && full) drop_ovf_o <= sat_inc(drop_ovf_o);
    end
  end
endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Scoreboard bench: queue-based reference model predicts handshakes and counters.
module tb_prefetch_issue_queue;
  localparam int CELLS = 27, DEPTH = 8, FN = 4, MAXO = 4;
  localparam int PH_IDLE = 0, PH_HOLD = 1, PH_WAIT = 2;

  logic        clock = 1'b0, reset;
  logic        pf_valid_i, flush_i, mem_req_ready_i, mem_rsp_valid_i;
  logic [31:0] pf_addr_i, mem_req_addr_o;
  logic        mem_req_valid_o, rsp_err_o;
  logic [2:0]  outstanding_o;
  logic [15:0] drop_oob_o, drop_dup_o, drop_ovf_o;

  prefetch_issue_queue dut (
    .clock(clock), .reset(reset), .pf_valid_i(pf_valid_i), .pf_addr_i(pf_addr_i),
    .flush_i(flush_i), .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_rsp_valid_i(mem_rsp_valid_i),
    .outstanding_o(outstanding_o), .drop_oob_o(drop_oob_o), .drop_dup_o(drop_dup_o),
    .drop_ovf_o(drop_ovf_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clock = ~clock;

  int          n_chk = 0, n_pass = 0, hs_cnt = 0;
  logic [31:0] sb[$];
  logic [31:0] sb_exp;

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_flt[FN];
  bit          m_fv[FN];
  int          m_fp, m_phase, m_out, m_oob, m_dup, m_ovf;
  logic [31:0] m_req;
  bit          m_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_q.delete();
    for (int i = 0; i < FN; i++) m_fv[i] = 0;
    m_fp = 0; m_phase = PH_IDLE; m_req = 0; m_out = 0; m_err = 0;
    m_oob = 0; m_dup = 0; m_ovf = 0;
  endtask

  function automatic bit m_is_dup(logic [31:0] a);
    foreach (m_q[i]) if (m_q[i] == a) return 1;
    for (int i = 0; i < FN; i++) if (m_fv[i] && m_flt[i] == a) return 1;
    return (m_phase == PH_HOLD) && (m_req == a);
  endfunction

  task automatic m_step(bit pv, logic [31:0] pa, bit fl, bit rdy, bit rsp);
    bit hs    = (m_phase == PH_HOLD) && rdy;
    int qn    = m_q.size();
    bit avail = (qn != 0) && !fl;
    bit do_push = 0;
    int nout;
    if (hs) sb.push_back(m_req);
    if (pv) begin
      if (pa >= CELLS)      begin if (m_oob < 65535) m_oob++; end
      else if (m_is_dup(pa)) begin if (m_dup < 65535) m_dup++; end
      else if (qn == DEPTH) begin if (m_ovf < 65535) m_ovf++; end
      else do_push = !fl;
    end
    nout = m_out + int'(hs) - int'(rsp);
    if (nout < 0) begin nout = 0; m_err = 1; end
    case (m_phase)
      PH_IDLE: if (avail) begin
        if (m_out < MAXO) begin m_req = m_q.pop_front(); m_phase = PH_HOLD; end
        else m_phase = PH_WAIT;
      end
      PH_HOLD: if (hs) begin
        m_flt[m_fp] = m_req; m_fv[m_fp] = 1; m_fp = (m_fp + 1) % FN;
        if (avail && nout < MAXO) m_req = m_q.pop_front();
        else m_phase = avail ? PH_WAIT : PH_IDLE;
      end
      default: if (m_out < MAXO || qn == 0) m_phase = PH_IDLE;
    endcase
    if (fl) begin
      m_q.delete();
      for (int i = 0; i < FN; i++) m_fv[i] = 0;
    end else if (do_push) m_q.push_back(pa);
    m_out = nout;
  endtask

  task automatic cycle(bit pv, logic [31:0] pa, bit fl, bit rdy, bit rsp);
    pf_valid_i = pv; pf_addr_i = pa; flush_i = fl;
    mem_req_ready_i = rdy; mem_rsp_valid_i = rsp;
    chk("req_valid", mem_req_valid_o, m_phase == PH_HOLD);
    if (m_phase == PH_HOLD) chk("req_addr", mem_req_addr_o, m_req);
    chk("outstanding", outstanding_o, m_out);
    chk("rsp_err", rsp_err_o, m_err);
    chk("drop_oob", drop_oob_o, m_oob);
    chk("drop_dup", drop_dup_o, m_dup);
    chk("drop_ovf", drop_ovf_o, m_ovf);
    m_step(pv, pa, fl, rdy, rsp);
    @(posedge clock); #1;
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) cycle(0, 0, 0, rdy, 0);
  endtask

  task automatic wait_valid(int budget, bit rdy);
    int k = 0;
    while (!mem_req_valid_o && k < budget) begin cycle(0, 0, 0, rdy, 0); k++; end
    chk("wait_valid", mem_req_valid_o, 1);
  endtask

  task automatic do_reset();
    pf_valid_i = 0; pf_addr_i = 0; flush_i = 0; mem_req_ready_i = 0; mem_rsp_valid_i = 0;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    m_reset();
    chk("rst_valid", mem_req_valid_o, 0);
    chk("rst_addr", mem_req_addr_o, 0);
    chk("rst_outst", outstanding_o, 0);
    chk("rst_drops", {drop_oob_o, drop_dup_o}, 0);
    chk("rst_ovf", drop_ovf_o, 0);
    chk("rst_err", rsp_err_o, 0);
  endtask

  // Monitor: every handshake the DUT presents must match the next predicted one.
  always @(negedge clock) begin
    if (!reset && mem_req_valid_o && mem_req_ready_i) begin
      hs_cnt++;
      n_chk++;
      if (sb.size() == 0)
        $display("FAIL sb_pop: unexpected handshake addr %0d expected none", mem_req_addr_o);
      else begin
        sb_exp = sb.pop_front();
        if (mem_req_addr_o === sb_exp) n_pass++;
        else $display("FAIL sb_addr: got %0d expected %0d", mem_req_addr_o, sb_exp);
      end
    end
  end

  initial begin
    int h0;
    reset = 1;
    m_reset();
    #12;

    // Single address, latency push+2
    do_reset();
    h0 = hs_cnt;
    cycle(1, 13, 0, 1, 0);
    chk("t1_n1_valid", mem_req_valid_o, 0);
    cycle(0, 0, 0, 1, 0);
    chk("t1_n2_valid", mem_req_valid_o, 1);
    chk("t1_n2_addr", mem_req_addr_o, 13);
    idle(3, 1);
    chk("t1_outst", outstanding_o, 1);
    chk("t1_hs", hs_cnt - h0, 1);
    chk("t1_nodrop", drop_oob_o + drop_dup_o + drop_ovf_o, 0);

    // Out of grid
    do_reset();
    h0 = hs_cnt;
    cycle(1, 27, 0, 1, 0);
    cycle(1, 100, 0, 1, 0);
    idle(4, 1);
    chk("t2_oob", drop_oob_o, 2);
    chk("t2_hs", hs_cnt - h0, 0);

    // Duplicates: FIFO hit then filter hit
    do_reset();
    h0 = hs_cnt;
    cycle(1, 4, 0, 1, 0);
    cycle(1, 4, 0, 1, 0);
    wait_valid(3, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 4, 0, 1, 0);
    idle(3, 1);
    chk("t3_dup", drop_dup_o, 2);
    chk("t3_hs", hs_cnt - h0, 1);

    // Overflow with ready held low
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, i, 0, 0, 0);
    chk("t4_ovf", drop_ovf_o, 1);
    idle(3, 0);
    chk("t4_hold_valid", mem_req_valid_o, 1);
    chk("t4_hold_addr", mem_req_addr_o, 0);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1, i % 2);

    // Outstanding cap and credit return
    do_reset();
    h0 = hs_cnt;
    for (int i = 10; i < 16; i++) cycle(1, i, 0, 1, 0);
    idle(8, 1);
    chk("t5_hs4", hs_cnt - h0, 4);
    chk("t5_cap", outstanding_o, 4);
    chk("t5_stall", mem_req_valid_o, 0);
    cycle(0, 0, 0, 1, 1);
    wait_valid(6, 1);
    cycle(0, 0, 0, 1, 1);
    chk("t5_same_cycle", outstanding_o, 3);
    idle(3, 1);
    chk("t5_hs6", hs_cnt - h0, 6);
    chk("t5_full", outstanding_o, 4);

    // Flush during REQ, re-send, response at zero
    do_reset();
    for (int i = 20; i < 24; i++) cycle(1, i, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("t6_held_valid", mem_req_valid_o, 1);
    chk("t6_held_addr", mem_req_addr_o, 20);
    cycle(0, 0, 0, 1, 0);
    idle(2, 1);
    chk("t6_outst", outstanding_o, 1);
    chk("t6_empty", mem_req_valid_o, 0);
    cycle(1, 21, 0, 1, 0);
    wait_valid(4, 1);
    chk("t6_resend", mem_req_addr_o, 21);
    chk("t6_nodup", drop_dup_o, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    chk("t6_no_err", rsp_err_o, 0);
    cycle(0, 0, 0, 1, 1);
    chk("t6_err", rsp_err_o, 1);
    chk("t6_zero", outstanding_o, 0);

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      logic [31:0] a;
      if (it == 1500) do_reset();
      a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 35));
      cycle($urandom_range(0, 9) < 6, a, $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
    end
    idle(2, 0);
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
